// File: rtl/cordic_req_arbiter.sv
// Round-robin arbiter that shares one pipelined CORDIC core between NUM_REQ requesters.
// Issued requester indices ride an in-order tag FIFO so each core result returns to its owner.
module cordic_req_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TAG_DEPTH = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          cfg_enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_W-1:0]             in_interface,
    output logic                          valid_in_interface,
    input  logic                          valid_out_interface,
    input  logic [DATA_W-1:0]             out_interface,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          busy,
    output logic [$clog2(TAG_DEPTH):0]    inflight,
    output logic                          err_orphan
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [IDX_W-1:0]     tag_mem [TAG_DEPTH];
    logic [DATA_W-1:0]    in_q, in_d;
    logic                 vin_q, vin_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic                 err_q, err_d;

    logic [NUM_REQ-1:0]   gnt_c;
    logic [IDX_W-1:0]     gnt_idx_c;
    logic                 gnt_found_c;
    logic                 full_c;
    logic                 empty_c;
    logic                 push_c;
    logic                 pop_c;
    int unsigned          arb_idx;
    int unsigned          rr_nxt;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign full_c  = (count_q == CNT_W'(TAG_DEPTH));
    assign empty_c = (count_q == '0);
    assign push_c  = gnt_found_c;
    assign pop_c   = valid_out_interface & ~empty_c;

    // Round-robin search starting at rr_q; at most one grant, only to a valid requester.
    always_comb begin
        gnt_c       = '0;
        gnt_idx_c   = '0;
        gnt_found_c = 1'b0;
        arb_idx     = 0;
        if (state_q == S_RUN && !full_c) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                arb_idx = 32'(rr_q) + k;
                if (arb_idx >= NUM_REQ) begin
                    arb_idx = arb_idx - NUM_REQ;
                end
                if (!gnt_found_c && req_valid[IDX_W'(arb_idx)]) begin
                    gnt_found_c = 1'b1;
                    gnt_idx_c   = IDX_W'(arb_idx);
                end
            end
            if (gnt_found_c) begin
                gnt_c[gnt_idx_c] = 1'b1;
            end
        end
    end

    assign req_ready = gnt_c;

    // Next-state, tag FIFO bookkeeping and registered output values.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        in_d        = '0;
        vin_d       = 1'b0;
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        err_d       = err_q;
        rr_nxt      = 0;

        case (state_q)
            S_IDLE:  if (cfg_enable) state_d = S_RUN;
            S_RUN:   if (!cfg_enable) state_d = S_DRAIN;
            S_DRAIN: begin
                if (cfg_enable) begin
                    state_d = S_RUN;
                end else if (empty_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push_c) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (gnt_c[i]) begin
                    in_d = req_data[i*DATA_W +: DATA_W];
                end
            end
            vin_d    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            rr_nxt   = 32'(gnt_idx_c) + 1;
            if (rr_nxt >= NUM_REQ) begin
                rr_nxt = 0;
            end
            rr_d = IDX_W'(rr_nxt);
        end

        if (pop_c) begin
            rsp_valid_d[tag_mem[rd_ptr_q]] = 1'b1;
            rsp_data_d                     = out_interface;
            rd_ptr_d                       = rd_ptr_q + PTR_W'(1);
        end

        if (valid_out_interface && empty_c) begin
            err_d = 1'b1;
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_q        <= '0;
            vin_q       <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_q        <= in_d;
            vin_q       <= vin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    // Tag storage needs no reset: entries are only read while the count says they are live.
    always_ff @(posedge HCLK) begin
        if (push_c) begin
            tag_mem[wr_ptr_q] <= gnt_idx_c;
        end
    end

    assign in_interface       = in_q;
    assign valid_in_interface = vin_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_data           = rsp_data_q;
    assign inflight           = count_q;
    assign err_orphan         = err_q;
    assign busy               = (state_q != S_IDLE) || (count_q != '0);

endmodule
